masked_barith_operand_prep: RTL and testbench
=============================================

Name: masked_barith_operand_prep

Overview:
- Upstream operand stage for the masked binary add/sub unit.
- Takes two Boolean-masked 32-bit operands (2 shares each) and an add/sub select.
- Produces masked propagate (mxor0/1 = shares of a^b') and masked generate (mand0/1 = shares of a&b'), using a registered DOM AND.
- Drives the adder's enable and holds all operands stable until the adder reports ready; then pulses done.

Parameters:
- XLEN, 32, operand width; fixed at 32, the adder is 32-bit only.

Ports:
- g_clk  in  1  clock
- g_resetn  in  1  asynchronous active-low reset
- flush  in  1  abort current operation, synchronous to g_clk
- i_valid  in  1  operand request
- i_ready  out  1  high only in IDLE; transfer = i_valid & i_ready
- sub  in  1  1: a-b, 0: a+b
- a0, a1  in  32  shares of operand a (a = a0^a1)
- b0, b1  in  32  shares of operand b
- rnd  in  32  fresh randomness for DOM cross terms; must be fresh every transfer
- mxor0, mxor1  out  32  propagate shares to adder
- mand0, mand1  out  32  generate shares to adder
- o_sub  out  1  registered sub, to adder sub input
- add_ena  out  1  adder enable
- add_rdy  in  1  adder ready/complete
- o_done  out  1  one-cycle pulse; adder outputs valid this cycle

Behaviour:
- Reset (g_resetn=0, asynchronous): state=IDLE; all data registers, mxor*, mand*, o_sub, add_ena and o_done = 0; i_ready=1 once reset releases.
- Register b' shares:
  - b'0 = sub ? ~b0 : b0
  - b'1 = b1
  - The adder injects the +1 carry for subtraction through o_sub.
- FSM states: IDLE, CROSS, COMP, ISSUE.
- IDLE:
  - i_ready=1.
  - On transfer: latch a0, a1, b'0, b'1, sub into input registers; go to CROSS.
  - No transfer: input registers stay 0.
- CROSS:
  - Load cross registers: c0 <= a0&b'1 ^ rnd; c1 <= a1&b'0 ^ rnd.
  - Load domain registers: d0 <= a0&b'0; d1 <= a1&b'1.
  - Go to COMP.
- COMP:
  - Load output registers: mand0 <= d0^c0; mand1 <= d1^c1; mxor0 <= a0^b'0; mxor1 <= a1^b'1.
  - Go to ISSUE.
- ISSUE:
  - add_ena=1 (registered, set on COMP->ISSUE).
  - mxor*, mand* and o_sub are held constant.
  - On add_rdy=1: o_done=1 for exactly this cycle (combinational from state & add_rdy); next state IDLE.
- Leaving ISSUE: all data registers, including mxor*/mand*, are zeroed on the next edge. No share combination ever sees stale values from a previous operation.
- Latency: transfer at cycle 0 -> add_ena high from cycle 3; o_done = cycle of add_rdy. Throughput is one operation per (3 + adder latency + 1) cycles.
- Shares are never combined in an unregistered XOR before the DOM register stage. No output depends on a0^a1 or b0^b1 combinationally.
- flush (highest priority after reset):
  - Next edge: state=IDLE, all data registers zeroed, add_ena=0.
  - o_done is suppressed in the same cycle even if add_rdy=1.
- i_valid while not IDLE is ignored; the source must hold it.
- add_rdy outside ISSUE is ignored.
- Simultaneous flush and transfer in IDLE: the flush wins and nothing is captured.

Optional Feature:
- MASKED_PREP_REFRESH_EN
  - Defined: adds input rnd2 [31:0]; in COMP, mxor0 <= a0^b'0^rnd2 and mxor1 <= a1^b'1^rnd2 (re-masked propagate).
  - Undefined: port absent, mxor unrefreshed as above.
  - Unmasked values are identical either way.

Test Plan:
- Add: a=5, b=3, a0=0x12345678, b0=0x9ABCDEF0, rnd=0x0F0F0F0F, sub=0 -> at add_ena rise: mxor0^mxor1=0x00000006, mand0^mand1=0x00000001, o_sub=0; add_rdy 6 cycles later -> o_done single pulse, i_ready=1 next cycle.
- Sub: a=5, b=3, sub=1 -> mxor0^mxor1=0xFFFFFFF9, mand0^mand1=0x00000004, o_sub=1.
- Mask independence: same a, b with 3 different random a0/b0/rnd -> unmasked results identical to scenario 1; mand0 differs between runs.
- Flush in ISSUE with add_rdy=1 same cycle -> o_done=0, next cycle state IDLE, add_ena=0, mxor*/mand*=0.
- Async reset asserted mid-CROSS between clock edges -> all outputs 0 immediately; after release, a new transfer completes normally.
- Back-to-back: i_valid held high across two operations -> second accepted only in the cycle after o_done; data registers read 0 for one cycle between the two operations.

Source files
------------

// File: rtl/masked_barith_operand_prep.sv
// masked_barith_operand_prep: masked operand stage feeding the masked binary add/sub unit.
//
// The two 2-share Boolean-masked operands are registered first. Masked generate
// shares come from a registered DOM AND, and masked propagate shares are formed
// from the registered operand shares. The stage then drives the adder and holds
// its outputs until the adder reports ready.
//
// Optional feature: define MASKED_PREP_REFRESH_EN to add input rnd2, which
// re-masks the propagate shares. The unmasked values are the same either way.
//
// Ports:
//   g_clk, g_resetn         clock; asynchronous active-low reset
//   flush                   synchronous abort, back to IDLE with data cleared
//   i_valid / i_ready       operand handshake (i_ready is high only in IDLE)
//   sub                     1: a-b, 0: a+b
//   a0,a1 / b0,b1           Boolean shares of a and b
//   rnd (rnd2)              fresh randomness for this transfer
//   mxor0/1, mand0/1        propagate and generate shares to the adder
//   o_sub, add_ena          registered sub select and adder enable
//   add_rdy / o_done        adder complete / one-cycle done pulse
module masked_barith_operand_prep #(
   parameter int XLEN = 32
) (
   input  logic            g_clk,
   input  logic            g_resetn,
   input  logic            flush,
   input  logic            i_valid,
   output logic            i_ready,
   input  logic            sub,
   input  logic [XLEN-1:0] a0,
   input  logic [XLEN-1:0] a1,
   input  logic [XLEN-1:0] b0,
   input  logic [XLEN-1:0] b1,
   input  logic [XLEN-1:0] rnd,
`ifdef MASKED_PREP_REFRESH_EN
   input  logic [XLEN-1:0] rnd2,
`endif
   output logic [XLEN-1:0] mxor0,
   output logic [XLEN-1:0] mxor1,
   output logic [XLEN-1:0] mand0,
   output logic [XLEN-1:0] mand1,
   output logic            o_sub,
   output logic            add_ena,
   input  logic            add_rdy,
   output logic            o_done
);
   typedef enum logic [1:0] {IDLE, CROSS, COMP, ISSUE} state_t;
   typedef struct packed {
      logic [XLEN-1:0] a0, a1, b0, b1, c0, c1, d0, d1, x0, x1, n0, n1;
      logic            sub, ena;
   } regs_t;
   state_t          state_q;
   regs_t           r_q;
   logic [XLEN-1:0] rm;
`ifdef MASKED_PREP_REFRESH_EN
   assign rm = rnd2;
`else
   assign rm = '0;
`endif
   assign i_ready = state_q == IDLE;
   assign o_done  = state_q == ISSUE && add_rdy && !flush;
   assign mxor0   = r_q.x0;
   assign mxor1   = r_q.x1;
   assign mand0   = r_q.n0;
   assign mand1   = r_q.n1;
   assign o_sub   = r_q.sub;
   assign add_ena = r_q.ena;
   // Every exit to IDLE (reset, flush, completion) clears all share registers,
   // so no later share combination can pick up values from an earlier operation.
   always_ff @(posedge g_clk or negedge g_resetn)
      if (!g_resetn) begin
         state_q <= IDLE;
         r_q     <= '0;
      end else if (flush || o_done) begin
         state_q <= IDLE;
         r_q     <= '0;
      end else
         case (state_q)
            IDLE:
               if (i_valid) begin
                  r_q.a0  <= a0;
                  r_q.a1  <= a1;
                  // Subtraction inverts b through one share only; the adder adds the +1.
                  r_q.b0  <= sub ? ~b0 : b0;
                  r_q.b1  <= b1;
                  r_q.sub <= sub;
                  state_q <= CROSS;
               end
            CROSS: begin
               // DOM cross terms are re-masked by rnd before they are registered.
               r_q.c0  <= (r_q.a0 & r_q.b1) ^ rnd;
               r_q.c1  <= (r_q.a1 & r_q.b0) ^ rnd;
               r_q.d0  <= r_q.a0 & r_q.b0;
               r_q.d1  <= r_q.a1 & r_q.b1;
               state_q <= COMP;
            end
            COMP: begin
               r_q.n0  <= r_q.d0 ^ r_q.c0;
               r_q.n1  <= r_q.d1 ^ r_q.c1;
               r_q.x0  <= r_q.a0 ^ r_q.b0 ^ rm;
               r_q.x1  <= r_q.a1 ^ r_q.b1 ^ rm;
               r_q.ena <= 1'b1;
               state_q <= ISSUE;
            end
            default: ;
         endcase
endmodule

// File: tb/tb_masked_barith_operand_prep.sv
// tb_masked_barith_operand_prep: scoreboard bench for the masked operand prep stage.
module tb_masked_barith_operand_prep;
   logic        g_clk = 0, g_resetn = 0, flush = 0, i_valid = 0, sub = 0, add_rdy = 0;
   logic [31:0] a0 = 0, a1 = 0, b0 = 0, b1 = 0, rnd = 0;
   logic [31:0] mxor0, mxor1, mand0, mand1;
`ifdef MASKED_PREP_REFRESH_EN
   logic [31:0] rnd2 = 32'h3C3C_A5A5;
`endif
   logic        i_ready, o_sub, add_ena, o_done;
   int          pass_cnt = 0, total = 0;
   typedef struct {logic [31:0] x, n, n0; logic s;} exp_t;
   exp_t        sb[$];
   logic        ena_prev = 0;

   always #5 g_clk = ~g_clk;

   masked_barith_operand_prep dut (
      .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush), .i_valid(i_valid), .i_ready(i_ready),
      .sub(sub), .a0(a0), .a1(a1), .b0(b0), .b1(b1), .rnd(rnd),
`ifdef MASKED_PREP_REFRESH_EN
      .rnd2(rnd2),
`endif
      .mxor0(mxor0), .mxor1(mxor1), .mand0(mand0), .mand1(mand1),
      .o_sub(o_sub), .add_ena(add_ena), .add_rdy(add_rdy), .o_done(o_done)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitor: on each rising add_ena the adder-facing outputs are compared with
   // the oldest expected item.
   always @(negedge g_clk) begin
      exp_t e;
      if (add_ena && !ena_prev) begin
         if (sb.size() == 0) chk("unexpected_issue", 1, 0);
         else begin
            e = sb.pop_front();
            chk("propagate", mxor0 ^ mxor1, e.x);
            chk("generate", mand0 ^ mand1, e.n);
            chk("mand0_share", mand0, e.n0);
            chk("o_sub", o_sub, e.s);
         end
      end
      ena_prev = add_ena;
   end

   // Drive one transfer (called at posedge+1 while IDLE); returns in CROSS.
   task automatic issue(input logic [31:0] a, b, a0v, b0v, r, input logic s, input bit push);
      exp_t e;
      logic [31:0] bp;
      bp = s ? ~b : b;
      e.x = a ^ bp; e.n = a & bp; e.n0 = (a0v & bp) ^ r; e.s = s;
      if (push) sb.push_back(e);
      chk("i_ready_idle", i_ready, 1);
      a0 = a0v; a1 = a ^ a0v; b0 = b0v; b1 = b ^ b0v; rnd = r; sub = s; i_valid = 1;
      @(posedge g_clk); #1 i_valid = 0;
   endtask

   task automatic wait_ena();
      int n = 0;
      while (!add_ena && n < 10) begin
         @(posedge g_clk); #1 n++;
      end
      chk("ena_latency", n, 2);
   endtask

   task automatic complete(input int lat);
      logic [31:0] held;
      bit early = 0;
      held = mxor0;
      repeat (lat) begin
         @(negedge g_clk); if (o_done) early = 1;
         @(posedge g_clk); #1;
      end
      chk("no_early_done", early, 0);
      chk("mxor0_held", mxor0, held);
      add_rdy = 1;
      @(negedge g_clk); chk("o_done_pulse", o_done, 1);
      @(posedge g_clk); #1 add_rdy = 0;
      chk("o_done_single", o_done, 0);
      chk("i_ready_after", i_ready, 1);
      chk("ena_cleared", add_ena, 0);
      chk("data_zeroed", mxor0 | mxor1 | mand0 | mand1, 0);
   endtask

   initial begin
      logic [31:0] m[3];
      repeat (2) @(posedge g_clk);
      #1;
      chk("rst_outputs", mxor0 | mxor1 | mand0 | mand1, 0);
      chk("rst_ctrl", {o_sub, add_ena, o_done}, 0);
      chk("rst_i_ready", i_ready, 1);
      g_resetn = 1;
      @(posedge g_clk); #1;
      // Add with three different maskings; the unmasked results must not change.
      issue(5, 3, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 0, 1);
      wait_ena(); m[0] = mand0;
      complete(6);
      issue(5, 3, 32'hDEAD_BEEF, 32'h1111_1111, 32'hCAFE_BABE, 0, 1);
      wait_ena(); m[1] = mand0;
      complete(2);
      issue(5, 3, 32'h0000_0000, 32'hFFFF_FFFF, 32'h5555_5555, 0, 1);
      wait_ena(); m[2] = mand0;
      complete(1);
      chk("mand0_differs", {31'b0, m[0] != m[1] && m[1] != m[2] && m[0] != m[2]}, 1);
      // Subtraction.
      issue(5, 3, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 1, 1);
      wait_ena();
      complete(3);
      // Flush in ISSUE together with add_rdy.
      issue(32'hA5A5_0001, 32'h0F0F_1234, 32'h7777_8888, 32'h1357_9BDF, 32'h2468_ACE0, 0, 1);
      wait_ena();
      add_rdy = 1; flush = 1;
      @(negedge g_clk); chk("flush_no_done", o_done, 0);
      @(posedge g_clk); #1 add_rdy = 0; flush = 0;
      chk("flush_idle", i_ready, 1);
      chk("flush_ena", add_ena, 0);
      chk("flush_zero", mxor0 | mxor1 | mand0 | mand1, 0);
      // Asynchronous reset between edges while in CROSS.
      issue(9, 4, 32'h0BAD_F00D, 32'h0000_FFFF, 32'h1111_2222, 1, 0);
      chk("cross_o_sub", o_sub, 1);
      #2 g_resetn = 0;
      #1 chk("async_rst_outputs", mxor0 | mxor1 | mand0 | mand1, 0);
      chk("async_rst_ctrl", {o_sub, add_ena, o_done}, 0);
      chk("async_rst_i_ready", i_ready, 1);
      @(negedge g_clk); g_resetn = 1;
      @(posedge g_clk); #1;
      issue(32'hFFFF_FFFF, 1, 32'h8000_0001, 32'h4000_0000, 32'h0F0F_0F0F, 0, 1);
      wait_ena();
      complete(2);
      // Back-to-back with i_valid held high.
      issue(32'h0000_00F0, 32'h0000_003C, 32'hAAAA_5555, 32'h1234_4321, 32'h9999_6666, 0, 1);
      i_valid = 1;
      a0 = 32'h0101_0101; a1 = 32'h0101_0101 ^ 32'h8000_0007;
      b0 = 32'h7070_7070; b1 = 32'h7070_7070 ^ 32'h0000_0002; sub = 1;
      chk("busy_not_ready", i_ready, 0);
      sb.push_back('{x: 32'h8000_0007 ^ ~32'h2, n: 32'h8000_0007 & ~32'h2,
                     n0: (32'h0101_0101 & ~32'h2) ^ 32'h9999_6666, s: 1});
      wait_ena();
      add_rdy = 1;
      @(negedge g_clk); chk("b2b_done", o_done, 1);
      @(posedge g_clk); #1 add_rdy = 0;
      chk("b2b_gap_ready", i_ready, 1);
      chk("b2b_gap_zero", mxor0 | mand0 | {31'b0, o_sub}, 0);
      @(posedge g_clk); #1 i_valid = 0;
      chk("b2b_second_taken", i_ready, 0);
      wait_ena();
      complete(1);
      repeat (3) @(posedge g_clk);
      chk("scoreboard_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
